// File: rtl/kernel_cc_fifo_pkg.sv
// rtl/kernel_cc_fifo_pkg.sv - shared constants and elaboration checks for the kernel_cc SRL FIFO
// Contents:
//   clog2()                 constant function used to size counters and addresses
//   KCC_FIFO_CHECK_PARAMS   macro placed at module-item level; stops elaboration on illegal
//                           DEPTH (2..64), AF_LEVEL (1..DEPTH) or AE_LEVEL (0..DEPTH-1)
`ifndef KERNEL_CC_FIFO_PKG_SV
`define KERNEL_CC_FIFO_PKG_SV

`define KCC_FIFO_CHECK_PARAMS(depth, af, ae) \
    if ((depth) < 2 || (depth) > 64 || (af) < 1 || (af) > (depth) || (ae) < 0 || (ae) > (depth) - 1) begin : g_illegal_params \
        $fatal(1, "kernel_cc_fifo: illegal DEPTH / AF_LEVEL / AE_LEVEL combination"); \
    end

package kernel_cc_fifo_pkg;

    // Smallest n with 2**n >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/kernel_cc_fifo_srl_ex_shiftReg.sv
// rtl/kernel_cc_fifo_srl_ex_shiftReg.sv - shift-register storage with addressed combinational read
// Ports:
//   clk   in   clock
//   data  in   word shifted into entry[0] when ce = 1
//   ce    in   shift enable; entry[i+1] <= entry[i], entry[0] <= data
//   a     in   read address
//   q     out  entry[a], combinational
// Storage is deliberately not reset so it maps onto SRL primitives.
module kernel_cc_fifo_srl_ex_shiftReg #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sr[i] <= sr[i-1];
            end
            sr[0] <= data;
        end
    end

    assign q = sr[a];

endmodule

// File: rtl/kernel_cc_fifo_srl_ex.sv
// rtl/kernel_cc_fifo_srl_ex.sv - shift-register FIFO with occupancy count, almost flags and flush
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   if_din / if_write / if_write_ce / if_full_n    write side
//   if_read / if_read_ce / if_empty_n / if_dout    read side, show-ahead data
//   if_flush           synchronous discard of all contents (below reset, above read/write)
//   if_count           number of stored words
//   if_almost_full     registered, count >= AF_LEVEL
//   if_almost_empty    registered, count <= AE_LEVEL
module kernel_cc_fifo_srl_ex
    import kernel_cc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    localparam int CNT_WIDTH = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    output logic                  if_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic                  if_empty_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_flush,
    output logic [CNT_WIDTH-1:0]  if_count,
    output logic                  if_almost_full,
    output logic                  if_almost_empty
);

    localparam int ADDR_WIDTH = clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_LEVEL);

    `KCC_FIFO_CHECK_PARAMS(DEPTH, AF_LEVEL, AE_LEVEL)

    // Declaration initialisers give power-up values equal to the reset values.
    logic [CNT_WIDTH-1:0]  count_q   = '0;
    logic                  empty_n_q = 1'b0;
    logic                  full_n_q  = 1'b1;
    logic                  af_q      = (AF_C == '0);
    logic                  ae_q      = 1'b1;

    logic                  wr_eff;
    logic                  rd_eff;
    logic                  shift_en;
    logic [CNT_WIDTH-1:0]  next_count;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Gating with the registered flags makes count saturate at 0 and DEPTH by construction.
    assign wr_eff   = if_write && if_write_ce && full_n_q;
    assign rd_eff   = if_read && if_read_ce && empty_n_q;
    // Reset and flush outrank a write, so the word must not enter storage either.
    assign shift_en = wr_eff && !reset && !if_flush;

    always_comb begin
        next_count = count_q;
        if (wr_eff && !rd_eff) begin
            next_count = count_q + CNT_WIDTH'(1);
        end else if (rd_eff && !wr_eff) begin
            next_count = count_q - CNT_WIDTH'(1);
        end
    end

    // The oldest word sits at entry[count-1]; a simultaneous shift and read
    // leaves count unchanged, which moves the read point to the next oldest word.
    assign rd_addr = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset || if_flush) begin
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            af_q      <= (AF_C == '0);
            ae_q      <= 1'b1;
        end else begin
            count_q   <= next_count;
            empty_n_q <= (next_count != '0);
            full_n_q  <= (next_count != DEPTH_C);
            af_q      <= (next_count >= AF_C);
            ae_q      <= (next_count <= AE_C);
        end
    end

    kernel_cc_fifo_srl_ex_shiftReg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_storage (
        .clk  (clk),
        .data (if_din),
        .ce   (shift_en),
        .a    (rd_addr),
        .q    (if_dout)
    );

    assign if_count        = count_q;
    assign if_empty_n      = empty_n_q;
    assign if_full_n       = full_n_q;
    assign if_almost_full  = af_q;
    assign if_almost_empty = ae_q;

endmodule

// File: tb/tb_kernel_cc_fifo_srl_ex.sv
// tb/tb_kernel_cc_fifo_srl_ex.sv - scoreboard bench for kernel_cc_fifo_srl_ex (DEPTH=5, 8-bit)
module tb_kernel_cc_fifo_srl_ex;

    localparam int DW = 8;
    localparam int D  = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] if_din = '0;
    logic          if_write = 1'b0;
    logic          if_write_ce = 1'b0;
    logic          if_full_n;
    logic          if_read = 1'b0;
    logic          if_read_ce = 1'b0;
    logic          if_empty_n;
    logic [DW-1:0] if_dout;
    logic          if_flush = 1'b0;
    logic [2:0]    if_count;
    logic          if_almost_full;
    logic          if_almost_empty;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] sb [$];

    kernel_cc_fifo_srl_ex #(
        .DATA_WIDTH (DW),
        .DEPTH      (D),
        .AF_LEVEL   (4),
        .AE_LEVEL   (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .if_din          (if_din),
        .if_write        (if_write),
        .if_write_ce     (if_write_ce),
        .if_full_n       (if_full_n),
        .if_read         (if_read),
        .if_read_ce      (if_read_ce),
        .if_empty_n      (if_empty_n),
        .if_dout         (if_dout),
        .if_flush        (if_flush),
        .if_count        (if_count),
        .if_almost_full  (if_almost_full),
        .if_almost_empty (if_almost_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {count, empty_n, full_n, almost_full, almost_empty}
    function automatic logic [6:0] act_status();
        return {if_count, if_empty_n, if_full_n, if_almost_full, if_almost_empty};
    endfunction

    function automatic logic [6:0] exp_status();
        int n;
        n = sb.size();
        return {3'(n), (n != 0), (n != D), (n >= 4), (n <= 1)};
    endfunction

    // Drives one clock of stimulus and advances the reference model; outputs
    // are sampled 1 time unit after the edge by the scenario tasks.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                         input logic wce = 1'b1, input logic rce = 1'b1,
                         input logic fl = 1'b0, input logic rst = 1'b0);
        logic w_eff;
        logic r_eff;
        if_write    = w;
        if_din      = d;
        if_write_ce = wce;
        if_read     = r;
        if_read_ce  = rce;
        if_flush    = fl;
        reset       = rst;
        w_eff = w && wce && (sb.size() < D);
        r_eff = r && rce && (sb.size() > 0);
        @(posedge clk);
        #1;
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (r_eff) void'(sb.pop_front());
            if (w_eff) sb.push_back(d);
        end
        if_write = 1'b0; if_read = 1'b0; if_flush = 1'b0; reset = 1'b0;
        if_write_ce = 1'b0; if_read_ce = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (act_status() !== 7'b000_0_1_0_1) begin
            n_err++;
            $display("FAIL reset_status: got %b want %b", act_status(), 7'b000_0_1_0_1);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [5];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vals[i], 1'b0);
            n_vec++;
            if (act_status() !== exp_status()) begin
                n_err++;
                $display("FAIL fill_status[%0d]: got %b want %b", i, act_status(), exp_status());
            end
            n_vec++;
            if (if_dout !== 8'h11) begin
                n_err++;
                $display("FAIL fill_dout[%0d]: got %h want 11", i, if_dout);
            end
        end
        n_vec++;
        if (if_full_n !== 1'b0 || if_count !== 3'd5) begin
            n_err++;
            $display("FAIL fill_full: full_n=%b count=%0d want 0/5", if_full_n, if_count);
        end
    endtask

    task automatic test_full_write_drain();
        logic [DW-1:0] exp;
        cycle(1'b1, 8'h66, 1'b0);
        n_vec++;
        if (if_count !== 3'd5 || act_status() !== exp_status()) begin
            n_err++;
            $display("FAIL full_write_ignored: got %b want %b", act_status(), exp_status());
        end
        for (int i = 0; i < 5; i++) begin
            exp = sb[0];
            n_vec++;
            if (if_dout !== exp || if_dout === 8'h66) begin
                n_err++;
                $display("FAIL drain_dout[%0d]: got %h want %h", i, if_dout, exp);
            end
            cycle(1'b0, '0, 1'b1);
        end
        n_vec++;
        if (if_empty_n !== 1'b0 || act_status() !== exp_status()) begin
            n_err++;
            $display("FAIL drain_empty: got %b want %b", act_status(), exp_status());
        end
    endtask

    task automatic test_simul_mid();
        logic [DW-1:0] exp;
        cycle(1'b1, 8'hA0, 1'b0);
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        n_vec++;
        if (if_dout !== 8'hA0 || if_count !== 3'd3) begin
            n_err++;
            $display("FAIL mid_pre: dout=%h count=%0d want a0/3", if_dout, if_count);
        end
        cycle(1'b1, 8'hA3, 1'b1);
        n_vec++;
        if (if_dout !== 8'hA1 || if_count !== 3'd3) begin
            n_err++;
            $display("FAIL mid_rw: dout=%h count=%0d want a1/3", if_dout, if_count);
        end
        for (int i = 0; i < 3; i++) begin
            exp = sb[0];
            n_vec++;
            if (if_dout !== exp) begin
                n_err++;
                $display("FAIL mid_drain[%0d]: got %h want %h", i, if_dout, exp);
            end
            cycle(1'b0, '0, 1'b1);
        end
        n_vec++;
        if (act_status() !== exp_status()) begin
            n_err++;
            $display("FAIL mid_end_status: got %b want %b", act_status(), exp_status());
        end
    endtask

    task automatic test_simul_boundary();
        logic [DW-1:0] exp;
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        n_vec++;
        if (if_count !== 3'd4 || if_full_n !== 1'b1 || act_status() !== exp_status()) begin
            n_err++;
            $display("FAIL full_rw: got %b want %b", act_status(), exp_status());
        end
        for (int i = 0; i < 4; i++) begin
            exp = sb[0];
            n_vec++;
            if (if_dout !== exp || if_dout === 8'hEE) begin
                n_err++;
                $display("FAIL full_rw_drain[%0d]: got %h want %h", i, if_dout, exp);
            end
            cycle(1'b0, '0, 1'b1);
        end
        cycle(1'b1, 8'h7E, 1'b1);
        n_vec++;
        if (if_count !== 3'd1 || if_dout !== 8'h7E || if_empty_n !== 1'b1) begin
            n_err++;
            $display("FAIL empty_rw: count=%0d dout=%h want 1/7e", if_count, if_dout);
        end
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (act_status() !== 7'b000_0_1_0_1) begin
            n_err++;
            $display("FAIL flush_status: got %b want %b", act_status(), 7'b000_0_1_0_1);
        end
        cycle(1'b1, 8'h12, 1'b0);
        n_vec++;
        if (if_dout !== 8'h12 || if_count !== 3'd1) begin
            n_err++;
            $display("FAIL flush_rewrite: dout=%h count=%0d want 12/1", if_dout, if_count);
        end
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_ce_and_reset();
        cycle(1'b1, 8'hB0, 1'b0);
        cycle(1'b1, 8'hB1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (act_status() !== exp_status() || if_count !== 3'd3 || if_dout !== 8'hB0) begin
            n_err++;
            $display("FAIL write_ce0: got %b/%h want %b/b0", act_status(), if_dout, exp_status());
        end
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (act_status() !== exp_status() || if_count !== 3'd3 || if_dout !== 8'hB0) begin
            n_err++;
            $display("FAIL read_ce0: got %b/%h want %b/b0", act_status(), if_dout, exp_status());
        end
        cycle(1'b1, 8'hBC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (act_status() !== 7'b000_0_1_0_1) begin
            n_err++;
            $display("FAIL midstream_reset: got %b want %b", act_status(), 7'b000_0_1_0_1);
        end
        cycle(1'b1, 8'h3C, 1'b0);
        n_vec++;
        if (if_dout !== 8'h3C || act_status() !== exp_status()) begin
            n_err++;
            $display("FAIL post_reset_write: got %b/%h want %b/3c", act_status(), if_dout, exp_status());
        end
        cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_write_drain();
        test_simul_mid();
        test_simul_boundary();
        test_flush();
        test_ce_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
